// File: rtl/uart_rx_fifo.sv
// Receive-side byte buffer behind a UART receiver: captures each completed frame
// (rising edge of rx_ready) with its error flags into a show-ahead FIFO.
module uart_rx_fifo #(
    parameter int DEPTH_BITS = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_ena,
    input  logic [7:0]            i_rx_data,
    input  logic                  i_rx_ready,
    input  logic                  i_rx_parity_err,
    input  logic                  i_rx_frame_err,
    input  logic                  i_rd,
    output logic [7:0]            o_data,
    output logic                  o_parity_err,
    output logic                  o_frame_err,
    output logic                  o_empty,
    output logic                  o_full,
    output logic [DEPTH_BITS:0]   o_count,
    output logic                  o_overflow,
    input  logic                  i_overflow_clr
);
    localparam int DEPTH = 1 << DEPTH_BITS;
    localparam logic [DEPTH_BITS:0] FULL_COUNT = (DEPTH_BITS + 1)'(DEPTH);

    logic [9:0]            r_mem [DEPTH];
    logic [DEPTH_BITS-1:0] r_wr_ptr;
    logic [DEPTH_BITS-1:0] r_rd_ptr;
    logic [DEPTH_BITS:0]   r_count;
    logic                  r_ready_prev;
    logic                  r_overflow;

    logic                  w_wr_ev;
    logic                  w_rd_ev;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_wr_accept;
    logic                  w_drop;
    logic [9:0]            w_head;

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == FULL_COUNT);
    assign w_wr_ev     = i_ena & i_rx_ready & ~r_ready_prev;
    assign w_rd_ev     = i_ena & i_rd & ~w_empty;
    // A full FIFO still accepts a frame when a pop frees the head slot in the same cycle.
    assign w_wr_accept = w_wr_ev & (~w_full | w_rd_ev);
    assign w_drop      = w_wr_ev & w_full & ~w_rd_ev;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_ready_prev <= 1'b1;
            r_overflow   <= 1'b0;
        end else begin
            r_ready_prev <= i_rx_ready;
            if (w_wr_accept) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_ev) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr_accept, w_rd_ev})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (i_overflow_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // Storage is intentionally left out of reset.
    always_ff @(posedge i_clk) begin
        if (w_wr_accept) begin
            r_mem[r_wr_ptr] <= {i_rx_frame_err, i_rx_parity_err, i_rx_data};
        end
    end

    assign w_head       = w_empty ? 10'd0 : r_mem[r_rd_ptr];
    assign o_data       = w_head[7:0];
    assign o_parity_err = w_head[8];
    assign o_frame_err  = w_head[9];
    assign o_empty      = w_empty;
    assign o_full       = w_full;
    assign o_count      = r_count;
    assign o_overflow   = r_overflow;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: stimulus pushes expected entries into a
// scoreboard queue, a negedge monitor pops and compares on every accepted read.
module tb_uart_rx_fifo;
    localparam int DB = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ena = 1'b1;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_ready = 1'b1;
    logic          rx_pe = 1'b0;
    logic          rx_fe = 1'b0;
    logic          rd = 1'b0;
    logic          ovf_clr = 1'b0;
    logic [7:0]    o_data;
    logic          o_pe;
    logic          o_fe;
    logic          o_empty;
    logic          o_full;
    logic [DB:0]   o_count;
    logic          o_overflow;

    int checks = 0;
    int errors = 0;
    logic [9:0] sb [$];

    uart_rx_fifo #(.DEPTH_BITS(DB)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_ena          (ena),
        .i_rx_data      (rx_data),
        .i_rx_ready     (rx_ready),
        .i_rx_parity_err(rx_pe),
        .i_rx_frame_err (rx_fe),
        .i_rd           (rd),
        .o_data         (o_data),
        .o_parity_err   (o_pe),
        .o_frame_err    (o_fe),
        .o_empty        (o_empty),
        .o_full         (o_full),
        .o_count        (o_count),
        .o_overflow     (o_overflow),
        .i_overflow_clr (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end else begin
            $display("ok   %s = 0x%0h", name, act);
        end
    endtask

    // Monitor: every accepted pop must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n && ena && rd && !o_empty) begin
            logic [9:0] exp;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected actual=0x%0h expected=none", {o_fe, o_pe, o_data});
            end else begin
                exp = sb.pop_front();
                if ({o_fe, o_pe, o_data} !== exp) begin
                    errors++;
                    $display("FAIL pop_entry actual=0x%0h expected=0x%0h", {o_fe, o_pe, o_data}, exp);
                end else begin
                    $display("pop  entry 0x%0h", exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One frame: ready low for a cycle, then rising with the byte; optional
    // same-cycle read and overflow clear on the capture edge.
    task automatic send_frame(input logic [7:0] d, input logic pe, input logic fe,
                              input bit expect_store, input logic with_rd, input logic with_clr);
        rx_ready = 1'b0;
        tick();
        rx_data  = d;
        rx_pe    = pe;
        rx_fe    = fe;
        rx_ready = 1'b1;
        rd       = with_rd;
        ovf_clr  = with_clr;
        if (expect_store) sb.push_back({fe, pe, d});
        tick();
        rd      = 1'b0;
        ovf_clr = 1'b0;
    endtask

    task automatic do_read();
        rd = 1'b1;
        tick();
        rd = 1'b0;
    endtask

    initial begin
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (100) tick();
        check("idle_empty", o_empty, 1);
        check("idle_count", o_count, 0);
        check("idle_data", o_data, 8'h00);
        check("idle_overflow", o_overflow, 0);

        send_frame(8'hA5, 0, 0, 1, 0, 0);
        check("a5_empty", o_empty, 0);
        check("a5_count", o_count, 1);
        check("a5_data", o_data, 8'hA5);
        do_read();
        check("a5_read_empty", o_empty, 1);
        check("a5_read_count", o_count, 0);

        for (int i = 0; i < 16; i++) send_frame(8'(i), 0, 0, 1, 0, 0);
        check("fill_full", o_full, 1);
        check("fill_count", o_count, 16);
        send_frame(8'hFF, 0, 0, 0, 0, 0);
        check("drop_overflow", o_overflow, 1);
        check("drop_count", o_count, 16);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("clr_overflow", o_overflow, 0);

        send_frame(8'h55, 0, 0, 1, 1, 0);
        check("rdwr_full_count", o_count, 16);
        check("rdwr_full_overflow", o_overflow, 0);
        for (int i = 0; i < 16; i++) do_read();
        check("drain_empty", o_empty, 1);
        check("drain_data", o_data, 8'h00);

        send_frame(8'h3C, 1, 1, 1, 0, 0);
        send_frame(8'h42, 0, 0, 1, 0, 0);
        check("err_fe", o_fe, 1);
        check("err_pe", o_pe, 1);
        check("err_data", o_data, 8'h3C);
        do_read();
        check("clean_fe", o_fe, 0);
        check("clean_pe", o_pe, 0);
        check("clean_data", o_data, 8'h42);
        do_read();

        for (int i = 0; i < 16; i++) send_frame(8'h80 + 8'(i), 0, 0, 1, 0, 0);
        send_frame(8'hEE, 0, 0, 0, 0, 0);
        check("ovf_set", o_overflow, 1);
        send_frame(8'hEF, 0, 0, 0, 0, 1);
        check("ovf_set_beats_clr", o_overflow, 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_clr_alone", o_overflow, 0);
        for (int i = 0; i < 16; i++) do_read();
        check("drain2_empty", o_empty, 1);

        ena = 1'b0;
        send_frame(8'h99, 0, 0, 0, 0, 0);
        ena = 1'b1;
        check("ena_off_count", o_count, 0);
        check("ena_off_empty", o_empty, 1);

        for (int i = 0; i < 5; i++) send_frame(8'h10 + 8'(i), 0, 0, 1, 0, 0);
        check("mid_count", o_count, 5);
        rst_n = 1'b0;
        #1;
        check("rst_count", o_count, 0);
        check("rst_empty", o_empty, 1);
        check("rst_data", o_data, 8'h00);
        sb.delete();
        tick();
        rst_n = 1'b1;
        tick();
        send_frame(8'h7E, 0, 1, 1, 0, 0);
        check("post_rst_count", o_count, 1);
        do_read();
        check("post_rst_empty", o_empty, 1);
        check("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side byte buffer that sits directly downstream of the UART receiver.
- Detects end-of-frame on the receiver's ready output (0->1 transition) and captures the received byte together with its parity and frame error flags into a synchronous FIFO.
- Presents a show-ahead read interface to the host logic, with full/empty status, occupancy count and a sticky overflow flag.

Parameters:
DEPTH_BITS, 4, log2 of FIFO depth; depth = 2^DEPTH_BITS entries, each entry 10 bits {frame_err, parity_err, data[7:0]}

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active-low
ena  input  1  enable; when low, no capture and no read take effect
rx_data  input  8  received byte from the UART receiver
rx_ready  input  1  receiver idle/data-valid flag; 0->1 transition marks frame complete
rx_parity_err  input  1  receiver parity error flag, valid with rx_data
rx_frame_err  input  1  receiver frame error flag, valid with rx_data
rd  input  1  read strobe; pops head entry when not empty
out_data  output  8  head entry byte (show-ahead)
out_parity_err  output  1  head entry parity error
out_frame_err  output  1  head entry frame error
empty  output  1  FIFO holds 0 entries
full  output  1  FIFO holds 2^DEPTH_BITS entries
count  output  DEPTH_BITS+1  current occupancy, 0..2^DEPTH_BITS
overflow  output  1  sticky: a completed frame was dropped because FIFO was full
overflow_clr  input  1  synchronous clear of overflow

Behaviour:
- Reset (rst=0, async): wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, overflow=0, ready_prev=1; out_data/out_parity_err/out_frame_err=0 while empty. Storage array contents are not reset.
- Edge detect: ready_prev <= rx_ready every clk, regardless of ena. Capture event wr_ev = ena & rx_ready & ~ready_prev. A ready held high after reset or at idle never produces a write.
- rx_data, rx_parity_err and rx_frame_err are sampled in the same cycle as wr_ev (receiver updates them in the same clock that ready rises).
- Read event rd_ev = ena & rd & ~empty. rd while empty is ignored; no pointer change, no error.
- Write accepted when wr_ev & (~full | rd_ev). Entry is stored at wr_ptr and wr_ptr increments modulo 2^DEPTH_BITS.
- On rd_ev, rd_ptr increments modulo 2^DEPTH_BITS. Outputs show the new head on the following cycle.
- count: +1 on write only, -1 on read only, unchanged on simultaneous write+read or neither. empty = (count==0), full = (count==2^DEPTH_BITS), both registered or derived from count with no extra latency.
- Latency: a frame captured at edge cycle N is visible on out_* with empty=0 at cycle N+1 (when the FIFO was empty).
- Outputs are 0 when empty; otherwise they are driven from storage[rd_ptr].
- Full boundary: wr_ev & full & ~rd_ev -> byte dropped, FIFO unchanged, overflow <= 1. wr_ev & full & rd_ev -> write accepted, count stays at max, no overflow.
- overflow: set has priority over overflow_clr in the same cycle; otherwise overflow_clr=1 clears it. overflow_clr is not gated by ena.
- Pointer wrap: pointers wrap naturally at DEPTH_BITS width; count distinguishes full from empty.
- Reset mid-operation: all state returns to reset values immediately; an edge occurring during reset is lost.

Test Plan:
- Reset, rx_ready held 1 for 100 cycles -> empty=1, count=0, no write; out_data=0x00.
- rx_data=0xA5, parity/frame err=0/0, rx_ready 0->1 -> next cycle empty=0, count=1, out_data=0xA5; pulse rd -> next cycle empty=1, count=0.
- Write 16 frames 0x00..0x0F (DEPTH_BITS=4) -> full=1, count=16; 17th frame 0xFF -> dropped, overflow=1; read all 16 -> sequence 0x00..0x0F in order, then empty=1.
- With FIFO full, rd pulse coinciding with the frame-complete edge for 0x55 -> count stays 16, overflow stays 0; last entry read out is 0x55.
- Frame with rx_frame_err=1, rx_parity_err=1, data 0x3C -> head shows out_frame_err=1, out_parity_err=1, out_data=0x3C; next clean frame shows both flags 0.
- overflow set, then overflow_clr asserted in the same cycle as a new drop -> overflow remains 1; overflow_clr alone -> overflow=0. Also: ena=0 during a frame-complete edge -> no write; assert rst mid-fill at count=5 -> count=0, empty=1.
